mpmc9_resp_line_gather: RTL and testbench
=========================================

# mpmc9_resp_line_gather

Read-response line gatherer for the mpmc9 memory controller. It sits directly downstream of the response strip counter. It captures each read-data strip from the memory interface into a line buffer slot indexed by the current strip count. When the last strip arrives, it presents the assembled line and its channel tag to the channel return logic with a valid/ready handshake.

## Interface
Parameters:
- STRIP_W, 128: width of one response strip (memory interface data width).
- NSTRIPS_MAX, 4: number of strip slots in the line buffer; `line_o` is STRIP_W*NSTRIPS_MAX bits.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- state  in  4  controller state; IDLE value from mpmc9_pkg.
- valid  in  1  read-data strip valid from the memory interface.
- data  in  STRIP_W  read-data strip.
- num_strips  in  6  index of the final strip of the burst; total strips = num_strips+1.
- strip_cnt  in  6  current strip index from the strip counter, sampled before its increment.
- ch_i  in  4  channel tag of the outstanding read.
- line_o  out  STRIP_W*NSTRIPS_MAX  assembled line; strip k at bits [k*STRIP_W +: STRIP_W].
- line_ch_o  out  4  channel tag for line_o.
- line_vld_o  out  1  line available.
- line_rdy_i  in  1  consumer accepts the line.
- busy_o  out  1  high in G_FILL or G_HOLD.
- overflow_o  out  1  sticky error flag (see Configuration).

## Operation
- FSM states and transitions:
  - G_IDLE → G_FILL on `valid`.
  - G_IDLE → G_HOLD on `valid` when num_strips==0.
  - G_FILL → G_HOLD on `valid` with strip_cnt==num_strips.
  - G_FILL → G_IDLE when state==IDLE (abort).
  - G_HOLD → G_IDLE when line_vld_o && line_rdy_i.
  - G_HOLD → G_FILL (or G_HOLD) when `valid` is high in the same cycle as the handoff.
- First strip of a line:
  - Clear all other slots of line_o to zero.
  - Write `data` into slot strip_cnt.
  - Latch ch_i into line_ch_o.
- Subsequent strips in G_FILL: write `data` into slot strip_cnt. Other slots are unchanged.
- Completion strip (strip_cnt==num_strips): write it, then hold line_o and line_ch_o stable throughout G_HOLD.
- A strip with strip_cnt ≥ NSTRIPS_MAX is not written. Completion detection still uses strip_cnt==num_strips.
- `valid` in G_HOLD without a same-cycle handoff is dropped; line_o is not modified.
- state==IDLE has no effect in G_IDLE or G_HOLD. A held line is always delivered.
- Abort from G_FILL: no line_vld_o pulse. line_o contents are don't-care until the next first strip.
- Slot index arithmetic: slot = strip_cnt[log2(NSTRIPS_MAX)-1:0], qualified by strip_cnt < NSTRIPS_MAX.

## Timing
- Reset values: line_o=0, line_ch_o=0, line_vld_o=0, busy_o=0, overflow_o=0, FSM=G_IDLE.
- Reset mid-line or mid-hold discards the line immediately; line_vld_o is low the next cycle.
- Latency: the completion strip is sampled at edge N; line_vld_o=1 and full line_o are valid after edge N.
- line_vld_o stays high until the edge where line_rdy_i=1 is sampled, then goes low the following cycle. The exception is a same-cycle new burst that completes immediately (num_strips==0), in which case line_vld_o remains high with the new line.
- line_rdy_i is ignored while line_vld_o=0.
- One strip is accepted per cycle; back-to-back `valid` is supported with no bubbles.
- busy_o is registered and equals (FSM != G_IDLE).

## Configuration
- MPMC9_RESP_GATHER_ERR_EN defined: overflow_o sets to 1 on either error condition and stays set until rst. Error conditions:
  - a strip is dropped in G_HOLD;
  - a strip has strip_cnt ≥ NSTRIPS_MAX.
- MPMC9_RESP_GATHER_ERR_EN undefined: overflow_o is tied to 0 and no detection logic is built. The drop behaviour is identical.

## Test plan
- num_strips=3, ch_i=5, four back-to-back valids with data 0xA..0xD, strip_cnt 0..3, line_rdy_i=1 → line_vld_o high the cycle after the 4th strip; line_o = {D,C,B,A}, line_ch_o=5; line_vld_o low the next cycle.
- num_strips=0, single valid with data 0x77 → G_HOLD directly; line_o slot0=0x77, slots1-3=0; line_vld_o high.
- Hold line_rdy_i=0 for 10 cycles after completion and inject valid in cycle 3 → line_o unchanged; line_vld_o stays high; overflow_o=1 only with the macro defined.
- Two strips of a num_strips=3 burst, then state=IDLE → busy_o low next cycle; no line_vld_o. A subsequent burst assembles correctly with unwritten slots zeroed.
- Handoff cycle (line_rdy_i=1) coincides with the first valid of the next burst → old line accepted; new line begins with slot0 written and a new line_ch_o.
- rst asserted in G_HOLD → next cycle all outputs 0 and FSM G_IDLE.

Source files
------------

// File: rtl/mpmc9_resp_line_gather.sv
// mpmc9_resp_line_gather
// Collects read-data strips from the memory interface into a line buffer and
// hands the finished line, with its channel tag, to the channel return logic.
//
// Parameters:
//   STRIP_W      width of one response strip
//   NSTRIPS_MAX  number of strip slots in the line buffer
//   IDLE_STATE   encoding of the controller IDLE state (matches mpmc9_pkg)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   state           controller state; IDLE while filling aborts the line
//   valid, data     read-data strip from the memory interface
//   num_strips      index of the final strip of the burst
//   strip_cnt       index of the current strip (before increment)
//   ch_i            channel tag of the outstanding read
//   line_o          assembled line, strip k at [k*STRIP_W +: STRIP_W]
//   line_ch_o       channel tag of line_o
//   line_vld_o      line available
//   line_rdy_i      consumer accepts the line
//   busy_o          gatherer is filling or holding a line
//   overflow_o      sticky error flag
//
// Optional feature: define MPMC9_RESP_GATHER_ERR_EN to build the sticky error
// detection behind overflow_o; otherwise overflow_o is tied low.
module mpmc9_resp_line_gather #(
  parameter int unsigned STRIP_W     = 128,
  parameter int unsigned NSTRIPS_MAX = 4,
  parameter logic [3:0]  IDLE_STATE  = 4'd0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     state,
  input  logic                           valid,
  input  logic [STRIP_W-1:0]             data,
  input  logic [5:0]                     num_strips,
  input  logic [5:0]                     strip_cnt,
  input  logic [3:0]                     ch_i,
  output logic [STRIP_W*NSTRIPS_MAX-1:0] line_o,
  output logic [3:0]                     line_ch_o,
  output logic                           line_vld_o,
  input  logic                           line_rdy_i,
  output logic                           busy_o,
  output logic                           overflow_o
);

  localparam int unsigned LINE_W = STRIP_W * NSTRIPS_MAX;

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_FILL = 2'd1,
    G_HOLD = 2'd2
  } gstate_e;

  gstate_e             gs_q, gs_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [3:0]          ch_q, ch_d;
  logic                vld_q, vld_d;
  logic                busy_q, busy_d;

  logic last_c;
  logic in_range_c;
  logic abort_c;
  logic handoff_c;
  logic first_c;
  logic wr_c;

  // Strip qualification shared by the FSM and the datapath
  assign last_c     = (strip_cnt == num_strips);
  assign in_range_c = (32'(strip_cnt) < NSTRIPS_MAX);
  assign abort_c    = (state == IDLE_STATE);
  assign handoff_c  = vld_q && line_rdy_i;
  // A new line starts from idle, or from hold when the old line leaves this cycle
  assign first_c    = valid && ((gs_q == G_IDLE) || ((gs_q == G_HOLD) && handoff_c));
  assign wr_c       = first_c || ((gs_q == G_FILL) && valid && !abort_c);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      gs_q <= G_IDLE;
    end else begin
      gs_q <= gs_d;
    end
  end

  // Next-state logic
  always_comb begin
    gs_d = gs_q;
    unique case (gs_q)
      G_IDLE: begin
        if (valid) gs_d = last_c ? G_HOLD : G_FILL;
      end
      G_FILL: begin
        if (abort_c)              gs_d = G_IDLE;
        else if (valid && last_c) gs_d = G_HOLD;
      end
      G_HOLD: begin
        if (handoff_c) begin
          if (valid) gs_d = last_c ? G_HOLD : G_FILL;
          else       gs_d = G_IDLE;
        end
      end
      default: gs_d = G_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    line_d = line_q;
    ch_d   = ch_q;
    if (first_c) begin
      line_d = '0;
      ch_d   = ch_i;
    end
    if (wr_c && in_range_c) begin
      for (int unsigned k = 0; k < NSTRIPS_MAX; k++) begin
        if (strip_cnt == 6'(k)) line_d[k*STRIP_W +: STRIP_W] = data;
      end
    end
    vld_d  = (gs_d == G_HOLD);
    busy_d = (gs_d != G_IDLE);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      ch_q   <= 4'd0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      line_q <= line_d;
      ch_q   <= ch_d;
      vld_q  <= vld_d;
      busy_q <= busy_d;
    end
  end

`ifdef MPMC9_RESP_GATHER_ERR_EN
  logic drop_c;
  logic ovf_q, ovf_d;

  // Strip arriving while a line is held and not leaving is lost
  assign drop_c = (gs_q == G_HOLD) && valid && !handoff_c;

  always_comb begin
    ovf_d = ovf_q | drop_c | (valid && !in_range_c);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif

  assign line_o     = line_q;
  assign line_ch_o  = ch_q;
  assign line_vld_o = vld_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_mpmc9_resp_line_gather.sv
// Testbench for mpmc9_resp_line_gather: table of per-cycle vectors followed by
// a short hand-written sequence for handshake and reset corner cases.
module tb_mpmc9_resp_line_gather;

  localparam int unsigned SW = 128;
  localparam int unsigned NS = 4;
  localparam int unsigned LW = SW * NS;

`ifdef MPMC9_RESP_GATHER_ERR_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  localparam logic       H   = 1'b1;
  localparam logic       L   = 1'b0;
  localparam logic [3:0] BZ  = 4'd3;
  localparam logic [3:0] IDL = 4'd0;
  localparam logic [7:0] Z8  = 8'h00;

  typedef struct {
    logic          rst;
    logic [3:0]    st;
    logic          vld;
    logic [SW-1:0] data;
    logic [5:0]    ns;
    logic [5:0]    sc;
    logic [3:0]    ch;
    logic          rdy;
    logic [LW-1:0] e_line;
    logic          chk_line;
    logic [3:0]    e_ch;
    logic          e_vld;
    logic          e_busy;
    logic          e_ovf;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [3:0]    state;
  logic          valid;
  logic [SW-1:0] data;
  logic [5:0]    num_strips;
  logic [5:0]    strip_cnt;
  logic [3:0]    ch_i;
  logic [LW-1:0] line_o;
  logic [3:0]    line_ch_o;
  logic          line_vld_o;
  logic          line_rdy_i;
  logic          busy_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  mpmc9_resp_line_gather #(.STRIP_W(SW), .NSTRIPS_MAX(NS)) dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .valid      (valid),
    .data       (data),
    .num_strips (num_strips),
    .strip_cnt  (strip_cnt),
    .ch_i       (ch_i),
    .line_o     (line_o),
    .line_ch_o  (line_ch_o),
    .line_vld_o (line_vld_o),
    .line_rdy_i (line_rdy_i),
    .busy_o     (busy_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] ln(input logic [7:0] d3, d2, d1, d0);
    return {SW'(d3), SW'(d2), SW'(d1), SW'(d0)};
  endfunction

  task automatic add(input logic r, input logic [3:0] st, input logic v,
                     input logic [7:0] d, input logic [5:0] ns, input logic [5:0] sc,
                     input logic [3:0] ch, input logic rdy, input logic [LW-1:0] el,
                     input logic cl, input logic [3:0] ec, input logic ev,
                     input logic eb, input logic eo);
    vec_t t;
    t.rst = r; t.st = st; t.vld = v; t.data = SW'(d); t.ns = ns; t.sc = sc;
    t.ch = ch; t.rdy = rdy; t.e_line = el; t.chk_line = cl; t.e_ch = ec;
    t.e_vld = ev; t.e_busy = eb; t.e_ovf = eo;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] st, input logic v,
                       input logic [7:0] d, input logic [5:0] ns, input logic [5:0] sc,
                       input logic [3:0] ch, input logic rdy);
    rst = r; state = st; valid = v; data = SW'(d); num_strips = ns;
    strip_cnt = sc; ch_i = ch; line_rdy_i = rdy;
  endtask

  initial begin
    drive(H, BZ, L, Z8, 6'd0, 6'd0, 4'd0, L);

    // Reset state
    add(H, BZ, L, Z8, 6'd0, 6'd0, 4'd0, L, ln(Z8, Z8, Z8, Z8), H, 4'd0, L, L, L);
    // Four back-to-back strips, then handoff
    add(L, BZ, H, 8'h0A, 6'd3, 6'd0, 4'd5, H, ln(Z8, Z8, Z8, 8'h0A), H, 4'd5, L, H, L);
    add(L, BZ, H, 8'h0B, 6'd3, 6'd1, 4'd5, H, ln(Z8, Z8, 8'h0B, 8'h0A), H, 4'd5, L, H, L);
    add(L, BZ, H, 8'h0C, 6'd3, 6'd2, 4'd5, H, ln(Z8, 8'h0C, 8'h0B, 8'h0A), H, 4'd5, L, H, L);
    add(L, BZ, H, 8'h0D, 6'd3, 6'd3, 4'd5, H, ln(8'h0D, 8'h0C, 8'h0B, 8'h0A), H, 4'd5, H, H, L);
    add(L, BZ, L, Z8, 6'd3, 6'd0, 4'd5, H, ln(8'h0D, 8'h0C, 8'h0B, 8'h0A), H, 4'd5, L, L, L);
    // Single-strip line goes straight to hold with other slots cleared
    add(L, BZ, H, 8'h77, 6'd0, 6'd0, 4'd2, L, ln(Z8, Z8, Z8, 8'h77), H, 4'd2, H, H, L);
    // Ten cycles without ready, dropped strip in cycle 3, controller IDLE ignored
    for (int i = 0; i < 10; i++) begin
      if (i == 2)
        add(L, IDL, H, 8'h99, 6'd0, 6'd0, 4'd7, L, ln(Z8, Z8, Z8, 8'h77), H, 4'd2, H, H, OVF);
      else
        add(L, IDL, L, Z8, 6'd0, 6'd0, 4'd2, L, ln(Z8, Z8, Z8, 8'h77), H, 4'd2, H, H,
            (i > 2) ? OVF : L);
    end
    add(L, BZ, L, Z8, 6'd0, 6'd0, 4'd0, H, ln(Z8, Z8, Z8, 8'h77), H, 4'd2, L, L, OVF);
    // Two strips, then abort
    add(L, BZ, H, 8'h11, 6'd3, 6'd0, 4'd4, L, ln(Z8, Z8, Z8, 8'h11), H, 4'd4, L, H, OVF);
    add(L, BZ, H, 8'h22, 6'd3, 6'd1, 4'd4, L, ln(Z8, Z8, 8'h22, 8'h11), H, 4'd4, L, H, OVF);
    add(L, IDL, L, Z8, 6'd3, 6'd2, 4'd4, L, '0, L, 4'd0, L, L, OVF);
    add(L, IDL, L, Z8, 6'd3, 6'd0, 4'd4, H, '0, L, 4'd0, L, L, OVF);
    // Next burst clears the stale slot left by the aborted line
    add(L, BZ, H, 8'h55, 6'd2, 6'd0, 4'd6, L, ln(Z8, Z8, Z8, 8'h55), H, 4'd6, L, H, OVF);
    add(L, BZ, H, 8'h66, 6'd2, 6'd1, 4'd6, L, ln(Z8, Z8, 8'h66, 8'h55), H, 4'd6, L, H, OVF);
    add(L, BZ, H, 8'h88, 6'd2, 6'd2, 4'd6, L, ln(Z8, 8'h88, 8'h66, 8'h55), H, 4'd6, H, H, OVF);
    // Handoff coincides with first strip of a new burst; strip 4 is out of range
    add(L, BZ, H, 8'hE1, 6'd5, 6'd0, 4'd9, H, ln(Z8, Z8, Z8, 8'hE1), H, 4'd9, L, H, OVF);
    add(L, BZ, H, 8'hE2, 6'd5, 6'd1, 4'd9, L, ln(Z8, Z8, 8'hE2, 8'hE1), H, 4'd9, L, H, OVF);
    add(L, BZ, H, 8'hE3, 6'd5, 6'd4, 4'd9, L, ln(Z8, Z8, 8'hE2, 8'hE1), H, 4'd9, L, H, OVF);
    add(L, BZ, H, 8'hE4, 6'd5, 6'd5, 4'd9, L, ln(Z8, Z8, 8'hE2, 8'hE1), H, 4'd9, H, H, OVF);
    // Handoff with a single-strip burst keeps line_vld_o high
    add(L, BZ, H, 8'hF0, 6'd0, 6'd0, 4'hA, H, ln(Z8, Z8, Z8, 8'hF0), H, 4'hA, H, H, OVF);
    // Reset while holding
    add(H, BZ, H, 8'hAA, 6'd0, 6'd0, 4'd1, L, '0, H, 4'd0, L, L, L);
    add(L, BZ, L, Z8, 6'd0, 6'd0, 4'd1, L, '0, H, 4'd0, L, L, L);
    // Out-of-range single strip completes without writing
    add(L, BZ, H, 8'h12, 6'd4, 6'd4, 4'd1, L, '0, H, 4'd1, H, H, OVF);
    add(L, BZ, L, Z8, 6'd4, 6'd0, 4'd1, H, '0, H, 4'd1, L, L, OVF);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].st, vq[i].vld, vq[i].data[7:0], vq[i].ns, vq[i].sc,
            vq[i].ch, vq[i].rdy);
      @(posedge clk);
      #1;
      if (vq[i].chk_line) begin
        chk($sformatf("v%0d line", i), line_o, vq[i].e_line);
        chk($sformatf("v%0d ch", i), LW'(line_ch_o), LW'(vq[i].e_ch));
      end
      chk($sformatf("v%0d vld", i), LW'(line_vld_o), LW'(vq[i].e_vld));
      chk($sformatf("v%0d busy", i), LW'(busy_o), LW'(vq[i].e_busy));
      chk($sformatf("v%0d ovf", i), LW'(overflow_o), LW'(vq[i].e_ovf));
    end

    // Two-strip line, wait (bounded) for it to appear
    @(negedge clk);
    drive(L, BZ, H, 8'hC0, 6'd1, 6'd0, 4'd3, L);
    @(negedge clk);
    drive(L, BZ, H, 8'hC1, 6'd1, 6'd1, 4'd3, L);
    @(negedge clk);
    drive(L, BZ, L, Z8, 6'd1, 6'd0, 4'd3, L);
    for (int n = 0; n < 4 && !line_vld_o; n++) @(negedge clk);
    chk("seq vld wait", LW'(line_vld_o), LW'(H));
    chk("seq line", line_o, ln(Z8, Z8, 8'hC1, 8'hC0));
    chk("seq ch", LW'(line_ch_o), LW'(4'd3));
    // Line remains while ready is low
    repeat (3) @(negedge clk);
    chk("seq hold vld", LW'(line_vld_o), LW'(H));
    chk("seq hold line", line_o, ln(Z8, Z8, 8'hC1, 8'hC0));
    // Handoff together with the first strip of a four-strip burst
    drive(L, BZ, H, 8'hD0, 6'd3, 6'd0, 4'd8, H);
    @(negedge clk);
    chk("seq ho vld", LW'(line_vld_o), LW'(L));
    chk("seq ho busy", LW'(busy_o), LW'(H));
    chk("seq ho line", line_o, ln(Z8, Z8, Z8, 8'hD0));
    chk("seq ho ch", LW'(line_ch_o), LW'(4'd8));
    // Reset in the middle of filling
    drive(H, BZ, H, 8'hD1, 6'd3, 6'd1, 4'd8, L);
    @(negedge clk);
    chk("seq rst busy", LW'(busy_o), LW'(L));
    chk("seq rst vld", LW'(line_vld_o), LW'(L));
    chk("seq rst line", line_o, '0);
    drive(L, BZ, L, Z8, 6'd0, 6'd0, 4'd0, L);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
